// File: rtl/sd_spi_host.sv
// sd_spi_host: SPI-mode SD card byte engine on a two-register CPU port.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   ce                  SPI half-period enable
//   ioWr, ioRd, ioA     one-clock strobes; ioA: 0 = data, 1 = control/status
//   ioD, ioQ            CPU write data / read data
//   busy                transfer in progress
//   spiCs, spiCk        chip select (active low), SPI clock (mode 0)
//   spiMosi, spiMiso    serial data out / in
module sd_spi_host #(
    parameter logic [7:0] DUMMY     = 8'hFF,
    parameter logic       IDLE_MOSI = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ioWr,
    input  logic       ioRd,
    input  logic       ioA,
    input  logic [7:0] ioD,
    output logic [7:0] ioQ,
    output logic       busy,
    output logic       spiCs,
    output logic       spiCk,
    output logic       spiMosi,
    input  logic       spiMiso
);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_tx;
    logic [7:0]  r_sh;
    logic [7:0]  r_rx;
    logic [3:0]  r_tick;
    logic        r_ck;
    logic        r_cs;

    logic        w_start;
    logic        w_tick;
    logic        w_last;
    logic        w_busy;
    logic [7:0]  w_start_byte;

    // A write wins over a simultaneous read, so the read
    // neither triggers a DUMMY transfer nor changes the byte sent.
    assign w_start_byte = ioWr ? ioD : DUMMY;

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_start = 1'b0;
        w_tick  = 1'b0;
        w_last  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // ce in the start cycle is deliberately ignored
                if (!ioA && (ioWr || ioRd)) begin
                    w_start = 1'b1;
                    w_next  = ST_XFER;
                end
            end
            ST_XFER: begin
                w_busy = 1'b1;
                w_tick = ce;
                if (ce && (r_tick == 4'd15)) begin
                    w_last = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cs <= 1'b1;
        end else if (ioWr && ioA) begin
            r_cs <= ioD[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx   <= 8'h00;
            r_sh   <= 8'h00;
            r_rx   <= 8'hFF;
            r_tick <= 4'd0;
            r_ck   <= 1'b0;
        end else if (w_start) begin
            r_tx   <= w_start_byte;
            r_tick <= 4'd0;
            r_ck   <= 1'b0;
        end else if (w_tick) begin
            r_tick <= r_tick + 4'd1;
            if (!r_tick[0]) begin
                // even tick: rising edge, sample the card
                r_ck <= 1'b1;
                r_sh <= {r_sh[6:0], spiMiso};
            end else begin
                // odd tick: falling edge, present next bit
                r_ck <= 1'b0;
                r_tx <= {r_tx[6:0], 1'b0};
            end
            if (w_last) begin
                r_rx <= r_sh;
            end
        end
    end

    assign busy    = w_busy;
    assign spiCs   = r_cs;
    assign spiCk   = r_ck;
    // MOSI tracks the shifter MSB only while a byte is on the wire
    assign spiMosi = w_busy ? r_tx[7] : IDLE_MOSI;
    assign ioQ     = ioA ? {w_busy, 6'b000000, r_cs} : r_rx;

endmodule

// File: tb/tb_sd_spi_host.sv
// tb_sd_spi_host: scoreboard bench for sd_spi_host.
// Card model answers with a queued byte; MOSI bytes are captured on spiCk rises.
module tb_sd_spi_host;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce    = 1'b0;
    logic       ioWr  = 1'b0;
    logic       ioRd  = 1'b0;
    logic       ioA   = 1'b1;
    logic [7:0] ioD   = 8'h00;
    logic [7:0] ioQ;
    logic       busy;
    logic       spiCs;
    logic       spiCk;
    logic       spiMosi;
    logic       spiMiso;

    int errors = 0;
    int checks = 0;

    bit          ce_en     = 1'b0;
    logic [15:0] sb_q[$];
    logic [7:0]  card_cur  = 8'hFF;
    logic [7:0]  rx_model  = 8'hFF;
    logic [7:0]  mosi_cap  = 8'h00;
    int          rise_cnt  = 8;
    int          busy_clks = 0;
    int          ce_ticks  = 0;
    int          exp_clks  = 0;
    logic        prev_busy = 1'b0;
    logic        prev_ck   = 1'b0;

    sd_spi_host #(
        .DUMMY    (8'hFF),
        .IDLE_MOSI(1'b1)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .ioWr   (ioWr),
        .ioRd   (ioRd),
        .ioA    (ioA),
        .ioD    (ioD),
        .ioQ    (ioQ),
        .busy   (busy),
        .spiCs  (spiCs),
        .spiCk  (spiCk),
        .spiMosi(spiMosi),
        .spiMiso(spiMiso)
    );

    always #5 clock = ~clock;

    // ce toggles so every second clock is a tick
    always @(posedge clock) begin
        #2;
        ce = ce_en ? ~ce : 1'b0;
    end

    assign spiMiso = (rise_cnt < 8) ? card_cur[3'(7 - rise_cnt)] : 1'b1;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [15:0] e;
        if (reset) begin
            sb_q.delete();
            rx_model  = 8'hFF;
            prev_busy = 1'b0;
            prev_ck   = 1'b0;
        end else begin
            if (!prev_busy && busy) begin
                if (sb_q.size() == 0) begin
                    check("start_unexpected", 16'(1), 16'(0));
                end else begin
                    card_cur = sb_q[0][7:0];
                    check("start_mosi", 16'(spiMosi), 16'(sb_q[0][15]));
                end
                check("start_ck", 16'(spiCk), 16'(0));
                rise_cnt  = 0;
                mosi_cap  = 8'h00;
                busy_clks = 0;
                ce_ticks  = 0;
            end
            if (busy) begin
                busy_clks++;
                if (ce) ce_ticks++;
            end
            if (!prev_ck && spiCk) begin
                mosi_cap = {mosi_cap[6:0], spiMosi};
                rise_cnt++;
            end
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 16'(1), 16'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("mosi_byte", 16'(mosi_cap), 16'(e[15:8]));
                    rx_model = e[7:0];
                end
                check("rises", 16'(rise_cnt), 16'(8));
                check("ce_ticks", 16'(ce_ticks), 16'(16));
                if (exp_clks != 0)
                    check("busy_clks", 16'(busy_clks), 16'(exp_clks));
                check("idle_mosi", 16'(spiMosi), 16'(1));
                check("idle_ck", 16'(spiCk), 16'(0));
            end
            prev_busy = busy;
            prev_ck   = spiCk;
        end
    end

    task automatic strobe(input logic wr, input logic rd, input logic a,
                          input logic [7:0] d, input logic [7:0] exp_q,
                          input bit chk_q, input bit align,
                          input string tag);
        int n = 0;
        @(posedge clock);
        #1;
        while (align && ce !== 1'b0 && n < 4) begin
            @(posedge clock);
            #1;
            n++;
        end
        ioWr = wr;
        ioRd = rd;
        ioA  = a;
        ioD  = d;
        if (chk_q) begin
            #1;
            check(tag, 16'(ioQ), 16'(exp_q));
        end
        @(posedge clock);
        #1;
        ioWr = 1'b0;
        ioRd = 1'b0;
        ioA  = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clock);
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 16'(busy), 16'(0));
    endtask

    task automatic wait_ticks(input int k);
        int n = 0;
        @(negedge clock);
        while (ce_ticks < k && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("tick_timeout", 16'(ce_ticks >= k), 16'(1));
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clock);
        #1;
        check({tag, "_busy"}, 16'(busy), 16'(0));
        check({tag, "_ck"}, 16'(spiCk), 16'(0));
        check({tag, "_mosi"}, 16'(spiMosi), 16'(1));
        check({tag, "_cs"}, 16'(spiCs), 16'(1));
        ioA = 1'b0;
        #1;
        check({tag, "_rx"}, 16'(ioQ), 16'(8'hFF));
        ioA = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_checks("por");
        @(posedge clock);
        #1;
        reset = 1'b0;

        strobe(1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, "ctrl_rd");
        repeat (4) @(negedge clock);
        check("ctrl_rd_noxfer", 16'(busy), 16'(0));
        check("ctrl_rd_ck", 16'(spiCk), 16'(0));
        check("ctrl_rd_mosi", 16'(spiMosi), 16'(1));

        ce_en = 1'b1;
        strobe(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "");
        @(negedge clock);
        check("cs_low", 16'(spiCs), 16'(0));

        sb_q.push_back({8'hA5, 8'h3C});
        exp_clks = 32;
        strobe(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, "");
        wait_idle(100);
        exp_clks = 0;

        sb_q.push_back({8'hFF, 8'h5A});
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0, "rd_3C");
        strobe(1'b0, 1'b1, 1'b1, 8'h00, 8'h80, 1'b1, 1'b0, "ctrl_busy");
        wait_idle(100);
        sb_q.push_back({8'hFF, 8'h00});
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, "rd_5A");
        wait_idle(100);

        sb_q.push_back({8'h22, 8'h96});
        strobe(1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, "");
        wait_ticks(5);
        strobe(1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, "");
        strobe(1'b0, 1'b1, 1'b0, 8'h00, rx_model, 1'b1, 1'b0, "rd_busy");
        strobe(1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, "");
        strobe(1'b0, 1'b1, 1'b1, 8'h00, 8'h81, 1'b1, 1'b0, "ctrl_cs_busy");
        strobe(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "");
        wait_idle(100);
        check("cs_kept", 16'(spiCs), 16'(0));
        sb_q.push_back({8'hFF, 8'h00});
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 8'h96, 1'b1, 1'b0, "rd_96");
        wait_idle(100);

        sb_q.push_back({8'h44, 8'h77});
        strobe(1'b1, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, "");
        wait_ticks(9);
        @(posedge clock);
        #1;
        reset = 1'b1;
        reset_checks("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb_q.push_back({8'hC3, 8'hE1});
        strobe(1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0, "");
        wait_idle(100);
        sb_q.push_back({8'hFF, 8'h00});
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 8'hE1, 1'b1, 1'b0, "rd_E1");
        wait_idle(100);

        sb_q.push_back({8'h81, 8'h18});
        strobe(1'b1, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, "");
        wait_ticks(6);
        @(posedge clock);
        #1;
        ce_en = 1'b0;
        repeat (2) @(negedge clock);
        begin
            logic ck0;
            logic mo0;
            int   changes;
            ck0 = spiCk;
            mo0 = spiMosi;
            changes = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clock);
                if (spiCk !== ck0 || spiMosi !== mo0 || busy !== 1'b1)
                    changes++;
            end
            check("freeze", 16'(changes), 16'(0));
        end
        ce_en = 1'b1;
        wait_idle(100);
        sb_q.push_back({8'hFF, 8'h00});
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 8'h18, 1'b1, 1'b0, "rd_18");
        wait_idle(100);

        sb_q.push_back({8'h3E, 8'hC5});
        strobe(1'b1, 1'b0, 1'b0, 8'h3E, 8'h00, 1'b0, 1'b0, "");
        sb_q.push_back({8'h5C, 8'h69});
        ioWr = 1'b1;
        ioA  = 1'b0;
        ioD  = 8'h5C;
        n = 0;
        @(negedge clock);
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("b2b_gap", 16'(busy), 16'(0));
        @(negedge clock);
        check("b2b_restart", 16'(busy), 16'(1));
        @(posedge clock);
        #1;
        ioWr = 1'b0;
        ioA  = 1'b1;
        wait_idle(100);
        sb_q.push_back({8'hFF, 8'h00});
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 8'h69, 1'b1, 1'b0, "rd_69");
        wait_idle(100);

        repeat (2) @(negedge clock);
        check("sb_empty", 16'(sb_q.size()), 16'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_spi_host.md
SD_SPI_HOST -- requirements
Module: sd_spi_host

Interface
REQ-001 The block SHALL have parameter DUMMY, default 8'hFF, meaning the byte shifted out on a read-triggered transfer.
REQ-002 The block SHALL have parameter IDLE_MOSI, default 1'b1, meaning the spiMosi level when no transfer is active.
REQ-003 clock  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ce  in  1  SPI bit-timing enable; one ce-qualified clock cycle is one SPI half-period.
REQ-006 ioWr  in  1  one-clock write strobe from the CPU port decoder.
REQ-007 ioRd  in  1  one-clock read strobe from the CPU port decoder.
REQ-008 ioA  in  1  register select: 0 = data, 1 = control/status.
REQ-009 ioD  in  8  CPU write data.
REQ-010 ioQ  out  8  CPU read data: the received byte when ioA=0, and {busy, 6'b0, spiCs} when ioA=1 (combinational on ioA).
REQ-011 busy  out  1  high while a byte transfer is in progress.
REQ-012 spiCs  out  1  card chip select, active low.
REQ-013 spiCk  out  1  SPI clock, mode 0 (idle low).
REQ-014 spiMosi  out  1  serial data to the card.
REQ-015 spiMiso  in  1  serial data from the card.

Function
REQ-016 A control write (ioWr=1, ioA=1) SHALL load spiCs from ioD[0] on that clock edge, whether or not busy is high.
REQ-017 A data write (ioWr=1, ioA=0) with busy low SHALL start a transfer of ioD.
REQ-018 A data read (ioRd=1, ioA=0) with busy low SHALL return the current rx byte and start a transfer of DUMMY.
REQ-019 A control read SHALL NOT start a transfer.
REQ-020 A data write or data read while busy is high SHALL be ignored: no restart, and no change to the shift register, rx byte or counter.
REQ-021 If ioWr and ioRd are both high, the write SHALL take precedence and the read SHALL NOT trigger a transfer.
REQ-022 Start edge: on the clock edge after the start cycle, busy=1, spiMosi=tx[7], spiCk=0 and the tick counter=0.
REQ-023 A ce that is high in the start cycle itself SHALL NOT be counted.
REQ-024 Each ce cycle while busy SHALL advance the 4-bit tick counter; no other cycle SHALL advance it.
REQ-025 On an even tick, spiCk SHALL go 0->1 and spiMiso SHALL be sampled into rx (MSB first).
REQ-026 On an odd tick, spiCk SHALL go 1->0 and tx SHALL shift left, presenting the next bit on spiMosi.
REQ-027 On tick 15, busy SHALL fall, the 8 sampled bits SHALL become the rx byte returned on ioQ (ioA=0), and spiMosi SHALL return to IDLE_MOSI.
REQ-028 A transfer SHALL last exactly 16 ce ticks and produce 8 rising spiCk edges.
REQ-029 A new transfer SHALL be accepted in the same cycle that busy is sampled low after completion.
REQ-030 With ce held low, the transfer SHALL hold state indefinitely, with no output change.
REQ-031 spiCs SHALL NOT be altered automatically by transfers; only control writes change it.

Reset
REQ-032 Asserting reset SHALL immediately force busy=0, spiCs=1, spiCk=0, spiMosi=IDLE_MOSI, rx byte=8'hFF and tick counter=0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer without a completion event.
REQ-034 The first strobe after reset release SHALL behave exactly as in REQ-016..REQ-021.

Verification
REQ-035 Reset then control read -> ioQ=8'h01, spiCk=0, spiMosi=1.
REQ-036 Control write 8'h00, data write 8'hA5, ce every 2nd clock, card model returns 8'h3C -> MOSI bits 1010_0101 seen on 8 rising edges; busy high for 32 clocks; then data read returns 8'h3C.
REQ-037 Data read with card returning 8'h5A -> ioQ = previous rx, MOSI shifts 8'hFF; busy falls; next data read returns 8'h5A.
REQ-038 Data write 8'h11 issued at tick 5 of an active transfer of 8'h22 -> ignored; completed byte on MOSI is 8'h22.
REQ-039 Reset asserted at tick 9 -> outputs at reset values next cycle; a following data write 8'hC3 completes normally in 16 ticks.
REQ-040 Simultaneous ioWr/ioRd at ioA=0 with ioD=8'h81 -> MOSI carries 8'h81, not DUMMY; ce held low for 50 clocks mid-transfer -> spiCk/spiMosi frozen.
